// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 membrane keypad model answering a row/column scanner
// One key at a time: bounce-in, hold, bounce-out, gap, with rows driven from cols like a real matrix.
module keypad_emulator #(
  parameter logic [15:0] HOLD_CYCLES   = 16'd2000,
  parameter logic [15:0] BOUNCE_CYCLES = 16'd64,
  parameter logic [15:0] BOUNCE_PERIOD = 16'd4,
  parameter logic [15:0] GAP_CYCLES    = 16'd256,
  parameter int          CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  input  logic [3:0] key_code,
  input  logic       press_valid,
  output logic       press_ready,
  output logic       busy,
  output logic       contact,
  output logic       done
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 16'd1);
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 16'd1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(BOUNCE_PERIOD - 16'd1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 16'd1);
  localparam logic             NO_BOUNCE   = (BOUNCE_CYCLES == 16'd0);
  localparam logic             NO_GAP      = (GAP_CYCLES == 16'd0);

  typedef enum logic [2:0] {
    S_IDLE, S_BOUNCE_IN, S_HOLD, S_BOUNCE_OUT, S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sub_q, sub_d;
  logic             contact_q, contact_d;
  logic [3:0]       code_q, code_d;
  logic             done_q, done_d;

  // True for the final busy cycle of a press; with no gap that is the end of the last active phase.
  function automatic logic is_last(state_t s, logic [CNT_W-1:0] c);
    is_last = ((s == S_GAP) && (c == GAP_LAST))
           || (NO_GAP && !NO_BOUNCE && (s == S_BOUNCE_OUT) && (c == BOUNCE_LAST))
           || (NO_GAP && NO_BOUNCE && (s == S_HOLD) && (c == HOLD_LAST));
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    sub_d     = sub_q;
    contact_d = contact_q;
    code_d    = code_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (press_valid) begin
          code_d    = key_code;
          sub_d     = '0;
          contact_d = 1'b1;
          state_d   = NO_BOUNCE ? S_HOLD : S_BOUNCE_IN;
        end
      end
      S_BOUNCE_IN, S_BOUNCE_OUT: begin
        if (sub_q == PERIOD_LAST) begin
          sub_d     = '0;
          contact_d = ~contact_q;
        end else begin
          sub_d = sub_q + 1'b1;
        end
        if (cnt_q == BOUNCE_LAST) begin
          cnt_d = '0;
          sub_d = '0;
          if (state_q == S_BOUNCE_IN) begin
            state_d   = S_HOLD;
            contact_d = 1'b1;
          end else begin
            state_d   = NO_GAP ? S_IDLE : S_GAP;
            contact_d = 1'b0;
          end
        end
      end
      S_HOLD: begin
        contact_d = 1'b1;
        if (cnt_q == HOLD_LAST) begin
          cnt_d     = '0;
          sub_d     = '0;
          contact_d = 1'b0;
          if (!NO_BOUNCE)   state_d = S_BOUNCE_OUT;
          else if (!NO_GAP) state_d = S_GAP;
          else              state_d = S_IDLE;
        end
      end
      S_GAP: begin
        contact_d = 1'b0;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        contact_d = 1'b0;
      end
    endcase
    done_d = (state_d != S_IDLE) && is_last(state_d, cnt_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sub_q     <= '0;
      contact_q <= 1'b0;
      code_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sub_q     <= sub_d;
      contact_q <= contact_d;
      code_q    <= code_d;
      done_q    <= done_d;
    end
  end

  // Matrix physics: any strobed column that matches the key's column lights the key's row.
  always_comb begin
    rows = '0;
    for (int r = 0; r < 4; r++) begin
      rows[r] = contact_q & (code_q[3:2] == 2'(r)) & cols[code_q[1:0]];
    end
  end

  assign press_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign contact     = contact_q;
  assign done        = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - three parameterisations driven together and compared against a press-timeline model
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       press_valid;

  always #5 clk = ~clk;

  localparam int N = 3;
  localparam int HOLD_P [N] = '{10, 40, 5};
  localparam int BC_P   [N] = '{0, 8, 7};
  localparam int BP_P   [N] = '{4, 2, 3};
  localparam int GAP_P  [N] = '{4, 12, 0};

  logic [3:0] rows_w    [N];
  logic       ready_w   [N];
  logic       busy_w    [N];
  logic       contact_w [N];
  logic       done_w    [N];

  keypad_emulator #(.HOLD_CYCLES(16'd10), .BOUNCE_CYCLES(16'd0), .BOUNCE_PERIOD(16'd4),
                    .GAP_CYCLES(16'd4), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .cols(cols), .rows(rows_w[0]), .key_code(key_code),
    .press_valid(press_valid), .press_ready(ready_w[0]), .busy(busy_w[0]),
    .contact(contact_w[0]), .done(done_w[0]));

  keypad_emulator #(.HOLD_CYCLES(16'd40), .BOUNCE_CYCLES(16'd8), .BOUNCE_PERIOD(16'd2),
                    .GAP_CYCLES(16'd12), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset(reset), .cols(cols), .rows(rows_w[1]), .key_code(key_code),
    .press_valid(press_valid), .press_ready(ready_w[1]), .busy(busy_w[1]),
    .contact(contact_w[1]), .done(done_w[1]));

  keypad_emulator #(.HOLD_CYCLES(16'd5), .BOUNCE_CYCLES(16'd7), .BOUNCE_PERIOD(16'd3),
                    .GAP_CYCLES(16'd0), .CNT_W(16)) u_dut_c (
    .clk(clk), .reset(reset), .cols(cols), .rows(rows_w[2]), .key_code(key_code),
    .press_valid(press_valid), .press_ready(ready_w[2]), .busy(busy_w[2]),
    .contact(contact_w[2]), .done(done_w[2]));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: pos = cycles elapsed since the accepting edge (0 = idle), sequence length = 2*bounce+hold+gap.
  int         pos    [N];
  logic [3:0] code_m [N];
  bit         chk_en = 1'b0;

  function automatic int seq_len(int i);
    return 2 * BC_P[i] + HOLD_P[i] + GAP_P[i];
  endfunction

  function automatic bit exp_contact(int i);
    int k;
    if (pos[i] == 0) return 1'b0;
    k = pos[i] - 1;
    if (k < BC_P[i]) return ((k / BP_P[i]) % 2) == 0;
    k -= BC_P[i];
    if (k < HOLD_P[i]) return 1'b1;
    k -= HOLD_P[i];
    if (k < BC_P[i]) return ((k / BP_P[i]) % 2) == 1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_rows(int i);
    if (exp_contact(i) && cols[code_m[i] % 4]) return 4'(1 << (code_m[i] / 4));
    return 4'b0000;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        pos[i]    <= 0;
        code_m[i] <= 4'h0;
      end else if (pos[i] == 0) begin
        if (press_valid) begin
          pos[i]    <= 1;
          code_m[i] <= key_code;
        end
      end else if (pos[i] == seq_len(i)) begin
        pos[i] <= 0;
      end else begin
        pos[i] <= pos[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("rows%0d", i), 32'(rows_w[i]), 32'(exp_rows(i)));
        check($sformatf("contact%0d", i), 32'(contact_w[i]), 32'(exp_contact(i)));
        check($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(pos[i] != 0));
        check($sformatf("ready%0d", i), 32'(ready_w[i]), 32'(pos[i] == 0));
        check($sformatf("done%0d", i), 32'(done_w[i]), 32'((pos[i] != 0) && (pos[i] == seq_len(i))));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] key);
    key_code    = key;
    press_valid = 1'b1;
    step();
    press_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit walk_cols);
    int n = 0;
    while ((pos[0] != 0 || pos[1] != 0 || pos[2] != 0) && n < 3000) begin
      if (walk_cols) cols = 4'(1 << $urandom_range(3));
      step();
      n++;
    end
    check("idle_timeout", 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_hold_b();
    int n = 0;
    while (pos[1] != BC_P[1] + 5 && n < 3000) begin
      step();
      n++;
    end
    check("hold_timeout", 32'(n < 3000), 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    cols        = 4'b0001;
    key_code    = 4'h0;
    press_valid = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;

    for (int j = 0; j < 8; j++) begin
      cols = 4'(1 << (j % 4));
      step();
    end

    press(4'b0110);
    wait_idle(1'b1);

    cols = 4'b0001;
    press(4'h0);
    wait_idle(1'b0);

    press(4'b0101);
    press_valid = 1'b1;
    key_code    = 4'hF;
    for (int j = 0; j < 6; j++) begin
      cols = 4'(1 << $urandom_range(3));
      step();
      key_code = 4'($urandom);
    end
    press_valid = 1'b0;
    wait_idle(1'b1);

    cols = 4'b0010;
    press(4'b1001);
    wait_hold_b();
    reset = 1'b1;
    step();
    reset = 1'b0;
    press(4'b0011);
    cols = 4'b1000;
    wait_idle(1'b0);

    press(4'b1001);
    wait_hold_b();
    cols = 4'b1111;
    repeat (4) step();
    cols = 4'b0000;
    repeat (3) step();
    wait_idle(1'b1);

    for (int j = 0; j < 5000; j++) begin
      cols        = ($urandom_range(3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(3));
      key_code    = 4'($urandom);
      press_valid = ($urandom_range(3) == 0);
      reset       = ($urandom_range(999) == 0);
      step();
    end
    reset       = 1'b0;
    press_valid = 1'b0;
    wait_idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
